// File: rtl/selector_out_ctrl.sv
// Sequencing controller for the 1-to-2 output selector with per-packet routing.
// Optional SELECTOR_OUT_CTRL_STATS_EN adds packet and stall counters.
module selector_out_ctrl #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENABLE,
  input  logic             MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_DEST,
  input  logic             IN_LAST,
  output logic             SELECT,
  output logic [WIDTH-1:0] DATA_IN,
  output logic             OUT_VALID_0,
  output logic             OUT_VALID_1,
  input  logic             OUT_READY_0,
  input  logic             OUT_READY_1,
  output logic             BUSY,
  output logic             ERR_OVERLEN
`ifdef SELECTOR_OUT_CTRL_STATS_EN
  ,
  output logic [31:0]      PKT_CNT_0,
  output logic [31:0]      PKT_CNT_1,
  output logic [31:0]      STALL_CNT
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0] CLAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PKT,
    S_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             hold_v_q;
  logic             hold_last_q;
  logic [WIDTH-1:0] data_q;

  logic in_fire;
  logic out_fire;
  logic sink_rdy;

  assign sink_rdy = sel_q ? OUT_READY_1 : OUT_READY_0;
  assign out_fire = hold_v_q & sink_rdy;

  // Held LAST blocks the next packet until it drains, freezing SELECT.
  assign IN_READY = RST_N & ENABLE
                  & (~hold_v_q | out_fire)
                  & ~(hold_v_q & hold_last_q);
  assign in_fire  = IN_VALID & IN_READY;

  assign SELECT      = sel_q;
  assign DATA_IN     = data_q;
  assign OUT_VALID_0 = hold_v_q & ~sel_q;
  assign OUT_VALID_1 = hold_v_q & sel_q;
  assign BUSY        = (state_q != S_IDLE) | hold_v_q;
  assign ERR_OVERLEN = err_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          sel_d   = MODE ? rr_q : IN_DEST;
          rr_d    = MODE ? ~rr_q : rr_q;
          cnt_d   = CW'(1);
          state_d = IN_LAST ? S_DRAIN : S_PKT;
        end
      end
      S_PKT: begin
        if (in_fire) begin
          if (cnt_q != CMAX) cnt_d = cnt_q + CW'(1);
          if (cnt_q == CLAST && !IN_LAST) err_d = 1'b1;
          if (IN_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_fire && hold_last_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_v_q    <= 1'b0;
      hold_last_q <= 1'b0;
      data_q      <= '0;
    end else if (in_fire) begin
      hold_v_q    <= 1'b1;
      hold_last_q <= IN_LAST;
      data_q      <= IN_DATA;
    end else if (out_fire) begin
      hold_v_q    <= 1'b0;
    end
  end

`ifdef SELECTOR_OUT_CTRL_STATS_EN
  logic [31:0] pkt0_q, pkt1_q, stall_q;
  logic        stall;

  assign stall     = hold_v_q & ~sink_rdy;
  assign PKT_CNT_0 = pkt0_q;
  assign PKT_CNT_1 = pkt1_q;
  assign STALL_CNT = stall_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pkt0_q  <= '0;
      pkt1_q  <= '0;
      stall_q <= '0;
    end else begin
      if (out_fire && hold_last_q && !sel_q) pkt0_q <= pkt0_q + 32'd1;
      if (out_fire && hold_last_q && sel_q)  pkt1_q <= pkt1_q + 32'd1;
      if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_selector_out_ctrl.sv
// Directed bench for selector_out_ctrl: vector table plus corner sequences.
// Stats checks compile only with SELECTOR_OUT_CTRL_STATS_EN.
module tb_selector_out_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ENABLE, MODE, IN_VALID, IN_DEST, IN_LAST;
  logic        OUT_READY_0, OUT_READY_1;
  logic [31:0] IN_DATA;
  logic        IN_READY, SELECT, OUT_VALID_0, OUT_VALID_1;
  logic        BUSY, ERR_OVERLEN;
  logic [31:0] DATA_IN;
`ifdef SELECTOR_OUT_CTRL_STATS_EN
  logic [31:0] PKT_CNT_0, PKT_CNT_1, STALL_CNT;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  selector_out_ctrl #(.WIDTH(32), .MAX_BURST(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .MODE(MODE),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .IN_DEST(IN_DEST), .IN_LAST(IN_LAST), .SELECT(SELECT),
    .DATA_IN(DATA_IN), .OUT_VALID_0(OUT_VALID_0),
    .OUT_VALID_1(OUT_VALID_1), .OUT_READY_0(OUT_READY_0),
    .OUT_READY_1(OUT_READY_1), .BUSY(BUSY), .ERR_OVERLEN(ERR_OVERLEN)
`ifdef SELECTOR_OUT_CTRL_STATS_EN
    , .PKT_CNT_0(PKT_CNT_0), .PKT_CNT_1(PKT_CNT_1),
    .STALL_CNT(STALL_CNT)
`endif
  );

  // Words actually taken by a sink: {select, data}.
  logic [32:0] got[$];
  always @(posedge CLK) begin
    if ((OUT_VALID_0 && OUT_READY_0) || (OUT_VALID_1 && OUT_READY_1))
      got.push_back({SELECT, DATA_IN});
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  task automatic drv(logic v, logic [31:0] d, logic dst, logic lst);
    IN_VALID = v;
    IN_DATA  = d;
    IN_DEST  = dst;
    IN_LAST  = lst;
  endtask

  task automatic chk_got(string name, logic [32:0] exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_word%0d", name, i), got[i], exp[i]);
  endtask

  typedef struct {
    logic        en, mode, vld;
    logic [31:0] data;
    logic        dest, last, r0, r1;
    logic        rdy, sel;
    logic [31:0] din;
    logic        ov0, ov1, busy;
  } vec_t;

  vec_t tbl[16];

`ifdef SELECTOR_OUT_CTRL_STATS_EN
  task automatic send1(logic dst, logic [31:0] d, int stalls);
    drv(1'b1, d, dst, 1'b1);
    nxt();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    if (dst) OUT_READY_1 = 1'b0; else OUT_READY_0 = 1'b0;
    for (int i = 0; i < stalls; i++) nxt();
    OUT_READY_0 = 1'b1;
    OUT_READY_1 = 1'b1;
    nxt();
  endtask
`endif

  initial begin
    logic [32:0] exp_q[$];

    tbl[0]  = '{1,0,1,32'hA,1,0,1,1, 1,0,32'h0,0,0,0};
    tbl[1]  = '{1,0,1,32'hB,1,0,1,1, 1,1,32'hA,0,1,1};
    tbl[2]  = '{1,0,1,32'hC,1,1,1,1, 1,1,32'hB,0,1,1};
    tbl[3]  = '{1,0,0,32'h0,0,0,1,1, 0,1,32'hC,0,1,1};
    tbl[4]  = '{1,0,0,32'h0,0,0,1,1, 1,1,32'hC,0,0,0};
    tbl[5]  = '{1,1,1,32'h1,0,1,1,1, 1,1,32'hC,0,0,0};
    tbl[6]  = '{1,1,1,32'h2,0,1,1,1, 0,0,32'h1,1,0,1};
    tbl[7]  = '{1,1,1,32'h2,0,1,1,1, 1,0,32'h1,0,0,0};
    tbl[8]  = '{1,1,1,32'h3,0,1,1,1, 0,1,32'h2,0,1,1};
    tbl[9]  = '{1,1,1,32'h3,0,1,1,1, 1,1,32'h2,0,0,0};
    tbl[10] = '{1,1,1,32'h4,0,1,1,1, 0,0,32'h3,1,0,1};
    tbl[11] = '{1,1,1,32'h4,0,1,1,1, 1,0,32'h3,0,0,0};
    tbl[12] = '{1,0,0,32'h0,0,0,1,1, 0,1,32'h4,0,1,1};
    tbl[13] = '{1,0,0,32'h0,0,0,1,1, 1,1,32'h4,0,0,0};
    tbl[14] = '{0,0,1,32'h5,0,1,1,1, 0,1,32'h4,0,0,0};
    tbl[15] = '{1,0,0,32'h0,0,0,1,1, 1,1,32'h4,0,0,0};

    RST_N = 1'b0;
    ENABLE = 1'b1;
    MODE = 1'b0;
    OUT_READY_0 = 1'b1;
    OUT_READY_1 = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_select", SELECT, 0);
    chk("rst_data_in", DATA_IN, 0);
    chk("rst_ov0", OUT_VALID_0, 0);
    chk("rst_ov1", OUT_VALID_1, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR_OVERLEN, 0);
    nxt();
    nxt();
    RST_N = 1'b1;

    got.delete();
    for (int i = 0; i < 16; i++) begin
      ENABLE      = tbl[i].en;
      MODE        = tbl[i].mode;
      OUT_READY_0 = tbl[i].r0;
      OUT_READY_1 = tbl[i].r1;
      drv(tbl[i].vld, tbl[i].data, tbl[i].dest, tbl[i].last);
      #1;
      chk($sformatf("v%0d_in_ready", i), IN_READY, tbl[i].rdy);
      chk($sformatf("v%0d_select", i), SELECT, tbl[i].sel);
      chk($sformatf("v%0d_data_in", i), DATA_IN, tbl[i].din);
      chk($sformatf("v%0d_ov0", i), OUT_VALID_0, tbl[i].ov0);
      chk($sformatf("v%0d_ov1", i), OUT_VALID_1, tbl[i].ov1);
      chk($sformatf("v%0d_busy", i), BUSY, tbl[i].busy);
      chk($sformatf("v%0d_err", i), ERR_OVERLEN, 0);
      nxt();
    end
    exp_q = '{{1'b1,32'hA}, {1'b1,32'hB}, {1'b1,32'hC},
              {1'b0,32'h1}, {1'b1,32'h2}, {1'b0,32'h3},
              {1'b1,32'h4}};
    chk_got("tbl", exp_q);

    // Sink 0 stalls for 5 cycles with a word held mid-packet.
    got.delete();
    MODE = 1'b0;
    drv(1'b1, 32'h10, 1'b0, 1'b0);
    #1 chk("stall_first_rdy", IN_READY, 1);
    nxt();
    OUT_READY_0 = 1'b0;
    drv(1'b1, 32'h11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d_data", i), DATA_IN, 32'h10);
      chk($sformatf("stall%0d_ov0", i), OUT_VALID_0, 1);
      chk($sformatf("stall%0d_ov1", i), OUT_VALID_1, 0);
      chk($sformatf("stall%0d_in_ready", i), IN_READY, 0);
      nxt();
    end
    OUT_READY_0 = 1'b1;
    #1 chk("stall_release_rdy", IN_READY, 1);
    nxt();
    drv(1'b1, 32'h12, 1'b0, 1'b1);
    #1 chk("stall_last_rdy", IN_READY, 1);
    nxt();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stall_drain_rdy", IN_READY, 0);
    chk("stall_drain_data", DATA_IN, 32'h12);
    nxt();
    #1 chk("stall_idle_busy", BUSY, 0);
    exp_q = '{{1'b0,32'h10}, {1'b0,32'h11}, {1'b0,32'h12}};
    chk_got("stall", exp_q);

    // 18-word packet overruns MAX_BURST=16.
    got.delete();
    exp_q = {};
    for (int i = 1; i <= 18; i++) begin
      drv(1'b1, 32'h100 + 32'(i), 1'b1, i == 18);
      #1;
      chk($sformatf("ovl%0d_rdy", i), IN_READY, 1);
      chk($sformatf("ovl%0d_err", i), ERR_OVERLEN, i > 16);
      exp_q.push_back({1'b1, 32'h100 + 32'(i)});
      nxt();
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    nxt();
    #1 chk("ovl_err_sticky", ERR_OVERLEN, 1);
    chk_got("ovl", exp_q);

    // Asynchronous reset while a word is held in S_PKT.
    OUT_READY_1 = 1'b0;
    drv(1'b1, 32'h77, 1'b1, 1'b0);
    nxt();
    drv(1'b1, 32'h78, 1'b1, 1'b1);
    #1;
    chk("pre_rst_select", SELECT, 1);
    chk("pre_rst_ov1", OUT_VALID_1, 1);
    chk("pre_rst_in_ready", IN_READY, 0);
    RST_N = 1'b0;
    #1;
    chk("arst_select", SELECT, 0);
    chk("arst_data_in", DATA_IN, 0);
    chk("arst_ov0", OUT_VALID_0, 0);
    chk("arst_ov1", OUT_VALID_1, 0);
    chk("arst_in_ready", IN_READY, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_err", ERR_OVERLEN, 0);
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    OUT_READY_1 = 1'b1;
    nxt();
    RST_N = 1'b1;
    got.delete();
    drv(1'b1, 32'h55, 1'b1, 1'b1);
    #1 chk("post_rst_rdy", IN_READY, 1);
    nxt();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("post_rst_select", SELECT, 1);
    chk("post_rst_data", DATA_IN, 32'h55);
    chk("post_rst_ov1", OUT_VALID_1, 1);
    nxt();
    // rr pointer restarts at sink 0 after reset.
    MODE = 1'b1;
    drv(1'b1, 32'h66, 1'b1, 1'b1);
    nxt();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    MODE = 1'b0;
    #1 chk("rr_after_rst_sel", SELECT, 0);
    nxt();
    #1 chk("post_rst_busy", BUSY, 0);
    exp_q = '{{1'b1,32'h55}, {1'b0,32'h66}};
    chk_got("post_rst", exp_q);

`ifdef SELECTOR_OUT_CTRL_STATS_EN
    RST_N = 1'b0;
    #1;
    chk("stats_rst_pkt0", PKT_CNT_0, 0);
    chk("stats_rst_pkt1", PKT_CNT_1, 0);
    chk("stats_rst_stall", STALL_CNT, 0);
    nxt();
    RST_N = 1'b1;
    send1(1'b0, 32'h200, 0);
    send1(1'b0, 32'h201, 0);
    send1(1'b1, 32'h202, 4);
    #1;
    chk("stats_pkt0", PKT_CNT_0, 2);
    chk("stats_pkt1", PKT_CNT_1, 1);
    chk("stats_stall", STALL_CNT, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
